hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
// Pipeline hazard/stall controller: generates stall/flush for the IF/ID and ID/EX pipeline
// registers (drives i_flush_exec of the decode preg) and operand forwarding selects for execute.
// Combinational load-use/mispredict/forwarding plus a registered cache-miss FSM that freezes the
// pipe until memory acks, with dual-miss arbitration and a wait watchdog.
// PARAMETERS
// REG_ADDR_W   5  register address width
// WDOG_W       8  watchdog counter width; timeout at 2**WDOG_W-1 wait cycles
// PORTS
// i_clk             in   1           clock
// i_arst            in   1           reset, asynchronous, active-high
// i_rs1_addr_dec    in   REG_ADDR_W  rs1 of instruction in decode
// i_rs2_addr_dec    in   REG_ADDR_W  rs2 of instruction in decode
// i_rs1_addr_exec   in   REG_ADDR_W  rs1 of instruction in execute
// i_rs2_addr_exec   in   REG_ADDR_W  rs2 of instruction in execute
// i_rd_addr_exec    in   REG_ADDR_W  rd in execute
// i_load_instr_exec in   1           execute holds a load
// i_rd_addr_mem     in   REG_ADDR_W  rd in memory stage
// i_reg_we_mem      in   1           memory-stage instr writes rd
// i_rd_addr_wb      in   REG_ADDR_W  rd in writeback
// i_reg_we_wb       in   1           writeback instr writes rd
// i_mispredict      in   1           execute redirects PC (taken branch/jump)
// i_icache_miss     in   1           fetch missed in I-cache
// i_dcache_miss     in   1           memory stage missed in D-cache
// i_mem_ack         in   1           outstanding refill complete (1-cycle pulse)
// o_stall_fetch     out  1           hold PC
// o_stall_decode    out  1           hold IF/ID register
// o_stall_exec      out  1           hold ID/EX and later registers
// o_flush_decode    out  1           clear IF/ID register
// o_flush_exec      out  1           clear ID/EX register (bubble)
// o_fwd_rs1         out  2           00 regfile, 01 WB result, 10 MEM result
// o_fwd_rs2         out  2           same encoding for rs2
// o_timeout         out  1           sticky watchdog flag
// BEHAVIOUR
// - FSM states: IDLE, DWAIT, IWAIT. Reset: state IDLE, pend_i=0, wdog=0, o_timeout=0.
// - While i_arst high all stall/flush outputs 0, fwd 00 (override of combinational terms).
// - IDLE: i_dcache_miss -> DWAIT (if i_icache_miss same cycle, set pend_i=1);
//   else i_icache_miss -> IWAIT. Transition registered; stall asserted combinationally in the
//   miss cycle itself (miss input high => all o_stall_* = 1, no flushes).
// - DWAIT/IWAIT: o_stall_fetch/decode/exec=1, flushes 0. On i_mem_ack: DWAIT with pend_i ->
//   IWAIT, clear pend_i; else -> IDLE. i_mem_ack in IDLE ignored.
// - i_icache_miss asserted during DWAIT sets pend_i (stays set until consumed).
// - Watchdog: wdog clears on entering wait, +1 per wait cycle, saturates at 2**WDOG_W-1; at
//   saturation set o_timeout (sticky to reset). FSM keeps waiting; no auto-recovery.
// - IDLE, no miss: load-use = i_load_instr_exec & rd_exec!=0 & rd_exec in {rs1_dec, rs2_dec}
//   -> o_stall_fetch=1, o_stall_decode=1, o_flush_exec=1.
//   i_mispredict -> o_flush_decode=1, o_flush_exec=1; mispredict overrides load-use stall
//   (stall_fetch/decode 0). Mispredict during wait held by stalled exec, acted on in IDLE.
// - Forwarding (always, incl. wait): rs==rd_mem & we_mem & rd_mem!=0 -> 10; else rs==rd_wb
//   & we_wb & rd_wb!=0 -> 01; else 00. x0 never forwarded.
// - Latency: stall/flush/fwd combinational, same cycle; FSM state one cycle later.
// - Reset mid-wait: immediate return to IDLE, pend_i and wdog cleared.
// TESTING
// - ld x5 in exec, decode rs1=5 -> stall_fetch=1, stall_decode=1, flush_exec=1 for 1 cycle.
// - rd_mem=3 we, rd_wb=3 we, rs2_exec=3 -> fwd_rs2=10; rd=0 we, rs1=0 -> fwd_rs1=00.
// - dcache+icache miss same cycle, ack at +5, ack at +9 -> DWAIT, IWAIT, IDLE; stalls 1 to +9.
// - mispredict + load-use same cycle -> flush_decode=1, flush_exec=1, stall_fetch=0.
// - WDOG_W=3, dcache miss, no ack -> o_timeout rises after 7 wait cycles, stalls stay 1.
// - arst pulse during DWAIT with pend_i -> IDLE, stalls 0, later ack has no effect.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
// Stall, flush and forwarding controls are combinational and take effect in the same cycle.
// A registered FSM holds the pipe frozen while an I-cache or D-cache refill is outstanding.
// A watchdog raises a sticky timeout flag if a refill wait runs too long.
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int WDOG_W     = 8
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
   input  logic                  i_load_instr_exec,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
   input  logic                  i_reg_we_mem,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
   input  logic                  i_reg_we_wb,
   input  logic                  i_mispredict,
   input  logic                  i_icache_miss,
   input  logic                  i_dcache_miss,
   input  logic                  i_mem_ack,
   output logic                  o_stall_fetch,
   output logic                  o_stall_decode,
   output logic                  o_stall_exec,
   output logic                  o_flush_decode,
   output logic                  o_flush_exec,
   output logic [1:0]            o_fwd_rs1,
   output logic [1:0]            o_fwd_rs2,
   output logic                  o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWAIT = 2'd1,
      ST_IWAIT = 2'd2
   } state_t;

   // Forwarding select encoding
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Watchdog saturation value and the value one below it
   localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
   localparam logic [WDOG_W-1:0] WDOG_NEAR = {{(WDOG_W-1){1'b1}}, 1'b0};

   state_t              state;
   logic                pend_i;   // I-cache miss seen while servicing a D-cache miss
   logic [WDOG_W-1:0]   wdog;

   logic                any_miss;
   logic                load_use;
   logic                wdog_hit;
   logic [WDOG_W-1:0]   wdog_inc;

   // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rd_mem,
      input logic                  we_mem,
      input logic [REG_ADDR_W-1:0] rd_wb,
      input logic                  we_wb
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (we_mem && (rd_mem != '0) && (rs == rd_mem))
         sel = FWD_MEM;
      else if (we_wb && (rd_wb != '0) && (rs == rd_wb))
         sel = FWD_WB;
      return sel;
   endfunction

   // Hazard detection terms shared by the FSM and the output logic
   always_comb begin
      any_miss = i_dcache_miss | i_icache_miss;
      load_use = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                 ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));
      // The timeout flag is set on the same edge the counter reaches saturation
      wdog_hit = (wdog == WDOG_NEAR) || (wdog == WDOG_MAX);
      wdog_inc = (wdog == WDOG_MAX) ? wdog : wdog + 1'b1;
   end

   // Refill-wait FSM with deferred I-miss, watchdog counter and sticky timeout flag
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state     <= ST_IDLE;
         pend_i    <= 1'b0;
         wdog      <= '0;
         o_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // D-miss has priority; a simultaneous I-miss is queued behind it
               if (i_dcache_miss) begin
                  state  <= ST_DWAIT;
                  pend_i <= i_icache_miss;
                  wdog   <= '0;
               end else if (i_icache_miss) begin
                  state  <= ST_IWAIT;
                  wdog   <= '0;
               end
            end
            ST_DWAIT: begin
               if (i_mem_ack) begin
                  state  <= pend_i ? ST_IWAIT : ST_IDLE;
                  pend_i <= 1'b0;
                  wdog   <= '0;
               end else begin
                  if (i_icache_miss)
                     pend_i <= 1'b1;
                  wdog <= wdog_inc;
                  if (wdog_hit)
                     o_timeout <= 1'b1;
               end
            end
            ST_IWAIT: begin
               if (i_mem_ack) begin
                  state <= ST_IDLE;
                  wdog  <= '0;
               end else begin
                  wdog <= wdog_inc;
                  if (wdog_hit)
                     o_timeout <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               pend_i <= 1'b0;
               wdog   <= '0;
            end
         endcase
      end
   end

   // Combinational stall/flush/forward outputs; reset forces them all quiet
   always_comb begin
      o_stall_fetch  = 1'b0;
      o_stall_decode = 1'b0;
      o_stall_exec   = 1'b0;
      o_flush_decode = 1'b0;
      o_flush_exec   = 1'b0;
      o_fwd_rs1      = FWD_RF;
      o_fwd_rs2      = FWD_RF;
      if (!i_arst) begin
         o_fwd_rs1 = fwd_sel(i_rs1_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                             i_rd_addr_wb, i_reg_we_wb);
         o_fwd_rs2 = fwd_sel(i_rs2_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                             i_rd_addr_wb, i_reg_we_wb);
         if ((state != ST_IDLE) || any_miss) begin
            // Whole pipe frozen; a pending mispredict stays in exec until released
            o_stall_fetch  = 1'b1;
            o_stall_decode = 1'b1;
            o_stall_exec   = 1'b1;
         end else if (i_mispredict) begin
            // Redirect squashes the younger instructions, so any load-use stall is moot
            o_flush_decode = 1'b1;
            o_flush_exec   = 1'b1;
         end else if (load_use) begin
            o_stall_fetch  = 1'b1;
            o_stall_decode = 1'b1;
            o_flush_exec   = 1'b1;
         end
      end
   end

endmodule
